// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
//   AHB-Lite SRAM slave with a configurable address width, depth and number of
//   wait states. It supports byte, halfword and word transfers with big-endian
//   byte lanes. Out-of-range and bad-size transfers get a two-cycle ERROR
//   response and never touch the memory.
//
//   Build option: define AHB_SRAM_ALIGN_CHECK_EN to make misaligned halfword
//   and word transfers take the ERROR path. When it is undefined, such
//   transfers are silently aligned down to their container.
module ahb_sram_slave #(
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_DEPTH   = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  // Word-index width. The word index comes from address bits [IDX_W+1:2].
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  // First illegal byte offset. It is 33 bits wide so the compare below cannot wrap.
  localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH) << 2;

  // Value of the wait counter on the last low-ready cycle.
  localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic       HAS_WAIT  = (WAIT_STATES > 0);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  // Byte-lane enables. Bit 3 is lane [31:24], which holds byte offset 0.
  function automatic logic [3:0] lane_en(input logic [2:0] size, input logic [1:0] ofs);
    logic [3:0] en;
    case (size)
      3'b000:  en = 4'b1000 >> ofs;
      3'b001:  en = ofs[1] ? 4'b0011 : 4'b1100;
      3'b010:  en = 4'b1111;
      default: en = 4'b0000;
    endcase
    return en;
  endfunction

  // Take enabled lanes from new_w and keep the remaining lanes of old_w.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  en);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = en[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
    end
    return res;
  endfunction

`ifdef AHB_SRAM_ALIGN_CHECK_EN
  // A halfword needs ofs[0]=0. A word needs ofs[1:0]=00.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] ofs);
    logic mis;
    case (size)
      3'b001:  mis = ofs[0];
      3'b010:  mis = (ofs != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction
`endif

  logic [2:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [2:0]            size_q, size_d;
  logic                  hreadyout_q;
  logic [1:0]            hresp_q;
  logic [31:0]           hrdata_q;

  logic [31:0]           mem_q [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] haddr_s;
  logic                  accept_s;
  logic                  in_range_s;
  logic                  size_ok_s;
  logic                  legal_s;
  logic [IDX_W-1:0]      wr_idx_s;
  logic [IDX_W-1:0]      rd_idx_s;
  logic                  wr_commit_s;
  logic [31:0]           wr_word_s;
  logic                  rd_load_s;
  logic [31:0]           rd_word_s;
  logic                  unused_s;

  assign haddr_s    = HADDR[ADDR_WIDTH-1:0];
  assign accept_s   = HSEL & HTRANS[1] & HREADY;
  assign in_range_s = (33'(haddr_s) < MEM_BYTES);
  assign size_ok_s  = (HSIZE <= 3'b010);
`ifdef AHB_SRAM_ALIGN_CHECK_EN
  assign legal_s    = in_range_s & size_ok_s & ~is_misaligned(HSIZE, haddr_s[1:0]);
`else
  assign legal_s    = in_range_s & size_ok_s;
`endif

  // The upper HADDR bits alias, and HBURST and HTRANS[0] carry no meaning for this slave.
  assign unused_s = ^{HADDR, HBURST, HTRANS[0], addr_q};

  // Next state. A new address phase is evaluated only where HREADYOUT is high.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept_s) begin
          addr_d  = haddr_s;
          write_d = HWRITE;
          size_d  = HSIZE;
          cnt_d   = 4'd0;
          if (!legal_s) begin
            state_d = ST_ERR1;
          end else if (HAS_WAIT) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // A write commits on the edge that ends its DATA cycle.
  assign wr_idx_s    = addr_q[IDX_W+1:2];
  assign wr_commit_s = (state_q == ST_DATA) & write_q;
  assign wr_word_s   = lane_merge(mem_q[wr_idx_s], HWDATA, lane_en(size_q, addr_q[1:0]));

  // Read data is loaded on the edge that enters DATA. A write that commits on
  // the same edge is forwarded, so back-to-back write/read sees the new data.
  assign rd_idx_s  = addr_d[IDX_W+1:2];
  assign rd_load_s = (state_d == ST_DATA) & ~write_d;
  assign rd_word_s = (wr_commit_s && (wr_idx_s == rd_idx_s)) ? wr_word_s : mem_q[rd_idx_s];

  // Control state, pending-phase registers and the registered bus outputs.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= 3'b000;
      hreadyout_q <= 1'b1;
      hresp_q     <= 2'b00;
      hrdata_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      size_q      <= size_d;
      hreadyout_q <= (state_d != ST_WAIT) && (state_d != ST_ERR1);
      hresp_q     <= ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? 2'b01 : 2'b00;
      if (rd_load_s) begin
        hrdata_q <= rd_word_s;
      end else begin
        hrdata_q <= hrdata_q;
      end
    end
  end

  // Storage array. It has no reset, and only a completing legal write updates it.
  always_ff @(posedge HCLK) begin
    if (wr_commit_s) begin
      mem_q[wr_idx_s] <= wr_word_s;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed bench for ahb_sram_slave.
// It uses two instances: u_ws0 (WAIT_STATES=0) and u_ws2 (WAIT_STATES=2).
// Both have MEM_DEPTH=256, so byte offset 0x400 is the first illegal offset.
module tb_ahb_sram_slave;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        sel2;
  logic        nrdy_force;

  logic        hsel0, hsel2, hready0, hready2;
  logic        hreadyout0, hreadyout2;
  logic [1:0]  hresp0, hresp2;
  logic [31:0] hrdata0, hrdata2;
  logic        rdy_m;
  logic [1:0]  resp_m;
  logic [31:0] rdata_m;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  assign hsel0   = ~sel2;
  assign hsel2   = sel2;
  assign hready0 = hreadyout0 & ~nrdy_force;
  assign hready2 = hreadyout2;
  assign rdy_m   = sel2 ? hreadyout2 : hreadyout0;
  assign resp_m  = sel2 ? hresp2 : hresp0;
  assign rdata_m = sel2 ? hrdata2 : hrdata0;

  ahb_sram_slave #(.ADDR_WIDTH(16), .MEM_DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite),
    .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(hready0), .HREADYOUT(hreadyout0), .HRESP(hresp0), .HRDATA(hrdata0)
  );

  ahb_sram_slave #(.ADDR_WIDTH(16), .MEM_DEPTH(256), .WAIT_STATES(2)) u_ws2 (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel2), .HADDR(haddr), .HWRITE(hwrite),
    .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(hready2), .HREADYOUT(hreadyout2), .HRESP(hresp2), .HRDATA(hrdata2)
  );

  // Compare one observed value against its expected value and log a mismatch.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Run one non-pipelined transfer. Call it #1 after an edge with the bus idle.
  // It returns #1 after the edge that follows completion.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic [1:0] resp_first, output logic [1:0] resp,
                      output int waits);
    int n;
    haddr  = addr;
    hwrite = wr;
    hsize  = size;
    htrans = 2'b10;
    @(posedge hclk); #1;
    htrans     = 2'b00;
    hwdata     = wdata;
    resp_first = resp_m;
    n = 0;
    while (!rdy_m && n < 20) begin
      @(posedge hclk); #1;
      n++;
    end
    check("xfer_bound", 32'(n < 20), 32'd1);
    waits = n;
    rdata = rdata_m;
    resp  = resp_m;
    @(posedge hclk); #1;
  endtask

  // Stop the run if it ever stalls outside the bounded loops.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  // Directed stimulus and checks.
  initial begin
    logic [31:0] rd;
    logic [1:0]  rs_first;
    logic [1:0]  rs;
    int          w;
    int          n;

    hreset = 1'b1; haddr = 32'd0; hwrite = 1'b0; htrans = 2'b00; hsize = 3'b010;
    hburst = 3'b001; hwdata = 32'd0; sel2 = 1'b0; nrdy_force = 1'b0;

    // Reset state of both instances.
    #12;
    check("rst_rdy0",   32'(hreadyout0), 32'd1);
    check("rst_resp0",  32'(hresp0),     32'd0);
    check("rst_rdata0", hrdata0,         32'd0);
    check("rst_rdy2",   32'(hreadyout2), 32'd1);
    check("rst_resp2",  32'(hresp2),     32'd0);
    @(posedge hclk); #1;
    hreset = 1'b0;
    @(posedge hclk); #1;

    // Word write followed by word read, with zero wait states.
    xfer(32'h0000_0010, 1'b1, 3'b010, 32'hA1B2_C3D4, rd, rs_first, rs, w);
    check("w1_waits", 32'(w), 32'd0);
    check("w1_resp",  32'(rs), 32'd0);
    xfer(32'h0000_0010, 1'b0, 3'b010, 32'd0, rd, rs_first, rs, w);
    check("r1_data",  rd, 32'hA1B2_C3D4);
    check("r1_resp",  32'(rs), 32'd0);
    check("r1_waits", 32'(w), 32'd0);

    // Byte write to offset 2 lands in lane [15:8] only.
    xfer(32'h0000_0010, 1'b1, 3'b010, 32'h1122_3344, rd, rs_first, rs, w);
    xfer(32'h0000_0012, 1'b1, 3'b000, 32'hAAAA_55AA, rd, rs_first, rs, w);
    xfer(32'h0000_0010, 1'b0, 3'b010, 32'd0, rd, rs_first, rs, w);
    check("byte_lane", rd, 32'h1122_5544);

    // Halfword write to offset 2 lands in lanes [15:0].
    xfer(32'h0000_0000, 1'b1, 3'b010, 32'h0000_0000, rd, rs_first, rs, w);
    xfer(32'h0000_0002, 1'b1, 3'b001, 32'h1234_BEEF, rd, rs_first, rs, w);
    xfer(32'h0000_0000, 1'b0, 3'b010, 32'd0, rd, rs_first, rs, w);
    check("half_lane", rd, 32'h0000_BEEF);

    // The last legal byte, offset 0x3FF, is lane [7:0] of word 0xFF.
    xfer(32'h0000_03FC, 1'b1, 3'b010, 32'h0102_0304, rd, rs_first, rs, w);
    xfer(32'h0000_03FF, 1'b1, 3'b000, 32'hDDDD_DDEE, rd, rs_first, rs, w);
    check("last_byte_resp", 32'(rs), 32'd0);
    xfer(32'h0000_03FC, 1'b0, 3'b010, 32'd0, rd, rs_first, rs, w);
    check("last_byte_data", rd, 32'h0102_03EE);

    // Offset 0x400 gets a two-cycle ERROR, and an errored write leaves memory unchanged.
    xfer(32'h0000_0400, 1'b0, 3'b010, 32'd0, rd, rs_first, rs, w);
    check("oob_resp1", 32'(rs_first), 32'd1);
    check("oob_waits", 32'(w),        32'd1);
    check("oob_resp2", 32'(rs),       32'd1);
    xfer(32'h0000_0400, 1'b1, 3'b010, 32'hFFFF_FFFF, rd, rs_first, rs, w);
    check("oob_wr_resp", 32'(rs), 32'd1);
    xfer(32'h0000_0000, 1'b0, 3'b010, 32'd0, rd, rs_first, rs, w);
    check("oob_no_write", rd, 32'h0000_BEEF);

    // A NONSEQ accepted during ERR2 completes OKAY.
    haddr = 32'h0000_0400; hwrite = 1'b0; hsize = 3'b010; htrans = 2'b10;
    @(posedge hclk); #1;
    htrans = 2'b00;
    check("err1_rdy",  32'(rdy_m),  32'd0);
    check("err1_resp", 32'(resp_m), 32'd1);
    @(posedge hclk); #1;
    check("err2_rdy",  32'(rdy_m),  32'd1);
    check("err2_resp", 32'(resp_m), 32'd1);
    haddr = 32'h0000_0010; htrans = 2'b10;
    @(posedge hclk); #1;
    htrans = 2'b00;
    check("err2p_rdy",  32'(rdy_m),  32'd1);
    check("err2p_resp", 32'(resp_m), 32'd0);
    check("err2p_data", rdata_m,     32'h1122_5544);
    @(posedge hclk); #1;

    // Address bits above ADDR_WIDTH alias onto the same word.
    xfer(32'h0001_0010, 1'b0, 3'b010, 32'd0, rd, rs_first, rs, w);
    check("alias_data", rd, 32'h1122_5544);

    // Back-to-back write then read of the same word, with zero wait states.
    haddr = 32'h0000_0020; hwrite = 1'b1; hsize = 3'b010; htrans = 2'b10;
    @(posedge hclk); #1;
    hwdata = 32'hCAFE_F00D; hwrite = 1'b0; htrans = 2'b10;
    @(posedge hclk); #1;
    htrans = 2'b00;
    check("raw_rdy",  32'(rdy_m), 32'd1);
    check("raw_data", rdata_m,    32'hCAFE_F00D);
    @(posedge hclk); #1;

    // While HREADY is low, a selected NONSEQ write is not accepted.
    nrdy_force = 1'b1;
    haddr = 32'h0000_0010; hwrite = 1'b1; hsize = 3'b010; htrans = 2'b10;
    hwdata = 32'hDEAD_DEAD;
    @(posedge hclk); #1;
    @(posedge hclk); #1;
    htrans = 2'b00; nrdy_force = 1'b0;
    @(posedge hclk); #1;
    xfer(32'h0000_0010, 1'b0, 3'b010, 32'd0, rd, rs_first, rs, w);
    check("nrdy_ignored", rd, 32'h1122_5544);

    // A misaligned word read at 0x0001.
    xfer(32'h0000_0001, 1'b0, 3'b010, 32'd0, rd, rs_first, rs, w);
`ifdef AHB_SRAM_ALIGN_CHECK_EN
    check("mis_resp1", 32'(rs_first), 32'd1);
    check("mis_resp2", 32'(rs),       32'd1);
`else
    check("mis_data",  rd,       32'h0000_BEEF);
    check("mis_resp",  32'(rs),  32'd0);
`endif

    // WAIT_STATES=2: pipelined write then read of word 0.
    sel2 = 1'b1;
    haddr = 32'h0000_0000; hwrite = 1'b1; hsize = 3'b010; htrans = 2'b10;
    @(posedge hclk); #1;
    hwdata = 32'h5A5A_A5A5; hwrite = 1'b0; htrans = 2'b10;
    n = 0;
    while (!rdy_m && n < 20) begin
      @(posedge hclk); #1;
      n++;
    end
    check("ws2_wr_waits", 32'(n), 32'd2);
    @(posedge hclk); #1;
    htrans = 2'b00;
    n = 0;
    while (!rdy_m && n < 20) begin
      @(posedge hclk); #1;
      n++;
    end
    check("ws2_rd_waits", 32'(n),  32'd2);
    check("ws2_rd_data",  rdata_m, 32'h5A5A_A5A5);
    check("ws2_rd_resp",  32'(resp_m), 32'd0);
    @(posedge hclk); #1;

    // A reset during WAIT drops the pending write and returns to idle at once.
    haddr = 32'h0000_0000; hwrite = 1'b1; hsize = 3'b010; htrans = 2'b10;
    @(posedge hclk); #1;
    htrans = 2'b00; hwdata = 32'hFFFF_FFFF;
    check("mw_rdy", 32'(rdy_m), 32'd0);
    #2;
    hreset = 1'b1;
    #1;
    check("mw_rst_rdy",   32'(hreadyout2), 32'd1);
    check("mw_rst_rdata", hrdata2,         32'd0);
    @(posedge hclk); #1;
    hreset = 1'b0;
    @(posedge hclk); #1;
    xfer(32'h0000_0000, 1'b0, 3'b010, 32'd0, rd, rs_first, rs, w);
    check("mw_discard", rd,      32'h5A5A_A5A5);
    check("mw_waits",   32'(w),  32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
